// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data memory (option macro: DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [DATA_SIZE-1:0]    wdata0,
    input  logic [DATA_SIZE-1:0]    wdata1,
    input  logic [1:0]              wsize0,
    input  logic [1:0]              wsize1,
    input  logic [2:0]              rsize0,
    input  logic [2:0]              rsize1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic [DATA_SIZE-1:0]    rdata0,
    output logic [DATA_SIZE-1:0]    rdata1,
    output logic                    err,
    output logic                    mem_rw,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    output logic [1:0]              mem_din,
    output logic [2:0]              mem_dout,
    input  logic [DATA_SIZE-1:0]    mem_rdata
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_we_q, cmd_we_d;
    logic [ADDRESS_SIZE-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_SIZE-1:0]    cmd_wdata_q, cmd_wdata_d;
    logic [1:0]              cmd_wsize_q, cmd_wsize_d;
    logic [2:0]              cmd_rsize_q, cmd_rsize_d;
    logic                    cmd_port_q, cmd_port_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic [DATA_SIZE-1:0]    rdata0_q, rdata0_d;
    logic [DATA_SIZE-1:0]    rdata1_q, rdata1_d;
    logic                    err_q, err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                    last_winner_q, last_winner_d;
`endif

    logic                    wsize_bad;
    logic                    rsize_ok;
    logic [DATA_SIZE-1:0]    rd_val;

    // State register plus command, response and status flops; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_wsize_q   <= 2'b00;
            cmd_rsize_q   <= 3'b000;
            cmd_port_q    <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            err_q         <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cmd_we_q      <= cmd_we_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_wsize_q   <= cmd_wsize_d;
            cmd_rsize_q   <= cmd_rsize_d;
            cmd_port_q    <= cmd_port_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            err_q         <= err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    // Grant selection: only in IDLE and never while reset is asserted
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE && !rst) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            gnt0 = req0;
            gnt1 = req1 & ~req0;
`else
            if (req0 && req1) begin
                // last_winner=1 means port 1 won last, so port 0 takes this round
                gnt0 = last_winner_q;
                gnt1 = ~last_winner_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
`endif
        end
    end

    // Next-state: every grant leads to exactly one ACCESS cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (gnt0 || gnt1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Size-code legality of the latched command
    always_comb begin
        wsize_bad = (cmd_wsize_q == 2'b11);
        rsize_ok  = 1'b0;
        case (cmd_rsize_q)
            3'b000, 3'b001, 3'b010, 3'b101, 3'b110: rsize_ok = 1'b1;
            default:                                rsize_ok = 1'b0;
        endcase
        rd_val = rsize_ok ? mem_rdata : '0;
    end

    // Command latch on grant; done, read capture and error tracking on the closing ACCESS edge
    always_comb begin
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wsize_d = cmd_wsize_q;
        cmd_rsize_d = cmd_rsize_q;
        cmd_port_d  = cmd_port_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        err_d       = err_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_winner_d = last_winner_q;
`endif
        if (gnt0) begin
            cmd_we_d    = we0;
            cmd_addr_d  = addr0;
            cmd_wdata_d = wdata0;
            cmd_wsize_d = wsize0;
            cmd_rsize_d = rsize0;
            cmd_port_d  = 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_winner_d = 1'b0;
`endif
        end else if (gnt1) begin
            cmd_we_d    = we1;
            cmd_addr_d  = addr1;
            cmd_wdata_d = wdata1;
            cmd_wsize_d = wsize1;
            cmd_rsize_d = rsize1;
            cmd_port_d  = 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_winner_d = 1'b1;
`endif
        end
        if (state_q == S_ACCESS) begin
            if (cmd_port_q) done1_d = 1'b1;
            else            done0_d = 1'b1;
            // Only the size code relevant to the access direction is judged
            if (cmd_we_q) begin
                if (wsize_bad) err_d = 1'b1;
            end else begin
                if (!rsize_ok) err_d = 1'b1;
                if (cmd_port_q) rdata1_d = rd_val;
                else            rdata0_d = rd_val;
            end
        end
    end

    // Memory-side outputs: command registers during ACCESS, quiet zeros otherwise
    always_comb begin
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_din   = 2'b00;
        mem_dout  = 3'b000;
        if (state_q == S_ACCESS) begin
            mem_rw    = cmd_we_q & ~wsize_bad & ~rst;
            mem_addr  = cmd_addr_q;
            mem_wdata = cmd_wdata_q;
            mem_din   = cmd_wsize_q;
            mem_dout  = cmd_rsize_q;
        end
    end

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed plus randomized self-checking bench for dmem_arbiter with a transaction-level model
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  wsize0, wsize1;
    logic [2:0]  rsize0, rsize1;
    logic        gnt0, gnt1, done0, done1, err, mem_rw;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_din;
    logic [2:0]  mem_dout;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] env_mem   [256];
    logic [31:0] model_mem [256];
    logic [31:0] model_rdata [2];
    logic        model_err;
    int          model_last;
    logic [2:0]  legal_rs [5];

    dmem_arbiter #(.DATA_SIZE(32), .ADDRESS_SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wsize0(wsize0), .wsize1(wsize1), .rsize0(rsize0), .rsize1(rsize1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] rs);
        case (rs)
            3'b000:  return w;
            3'b001:  return {{24{w[7]}}, w[7:0]};
            3'b010:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {24'h0, w[7:0]};
            3'b110:  return {16'h0, w[15:0]};
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    function automatic logic rs_legal(input logic [2:0] rs);
        return (rs == 3'b000) || (rs == 3'b001) || (rs == 3'b010) || (rs == 3'b101) || (rs == 3'b110);
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] ws);
        case (ws)
            2'b00:   return wd;
            2'b01:   return {old[31:8], wd[7:0]};
            2'b10:   return {old[31:16], wd[15:0]};
            default: return old;
        endcase
    endfunction

    // Memory device: combinational sized read, write on the rising edge when enabled
    always @(posedge clk) begin
        if (mem_rw) env_mem[mem_addr[7:0]] <= store_merge(env_mem[mem_addr[7:0]], mem_wdata, mem_din);
    end
    always_comb mem_rdata = load_ext(env_mem[mem_addr[7:0]], mem_dout);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        model_err      = 1'b0;
        model_last     = 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rw"},   32'(mem_rw), 32'h0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_wd"},   mem_wdata, 32'h0);
        check({tag, "_size"}, 32'({mem_din, mem_dout}), 32'h0);
    endtask

    // One single-port transaction, checked cycle by cycle from request to done
    task automatic do_access(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] ws, input logic [2:0] rs);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; wsize0 = ws; rsize0 = rs;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; wsize1 = ws; rsize1 = rs;
        end
        #1;
        check("gnt", 32'({gnt1, gnt0}), (p == 0) ? 32'h1 : 32'h2);
        check("req_rw", 32'(mem_rw), 32'h0);
        model_last = p;
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        check("acc_rw",   32'(mem_rw), 32'(we && ws != 2'b11));
        check("acc_addr", mem_addr, a);
        check("acc_size", 32'({mem_din, mem_dout}), 32'({ws, rs}));
        if (we) check("acc_wdata", mem_wdata, wd);
        check("acc_gnt",  32'({gnt1, gnt0}), 32'h0);
        check("acc_done", 32'({done1, done0}), 32'h0);
        if (we) begin
            if (ws == 2'b11) model_err = 1'b1;
            else model_mem[a[7:0]] = store_merge(model_mem[a[7:0]], wd, ws);
        end else if (rs_legal(rs)) begin
            model_rdata[p] = load_ext(model_mem[a[7:0]], rs);
        end else begin
            model_rdata[p] = 32'h0;
            model_err      = 1'b1;
        end
        tick();
        check("done",   32'({done1, done0}), (p == 0) ? 32'h1 : 32'h2);
        check("rdata0", rdata0, model_rdata[0]);
        check("rdata1", rdata1, model_rdata[1]);
        check("err",    32'(err), 32'(model_err));
        check("done_rw", 32'(mem_rw), 32'h0);
    endtask

    // Both ports hold read requests for n grants; winner order follows the arbitration rule
    task automatic rr_burst(input int n);
        int prev;
        int w;
        prev = -1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; rsize0 = 3'b000; rsize1 = 3'b000;
        for (int i = 0; i < n; i++) begin
            addr0 = 32'($urandom_range(0, 63));
            addr1 = 32'($urandom_range(0, 63));
            #1;
            if (prev >= 0) begin
                check("rr_done", 32'({done1, done0}), (prev == 0) ? 32'h1 : 32'h2);
                check("rr_rdata0", rdata0, model_rdata[0]);
                check("rr_rdata1", rdata1, model_rdata[1]);
            end
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = 1 - model_last;
`endif
            check("rr_gnt", 32'({gnt1, gnt0}), (w == 0) ? 32'h1 : 32'h2);
            model_last = w;
            model_rdata[w] = model_mem[(w == 0) ? addr0[7:0] : addr1[7:0]];
            tick();
            if (i == n - 1) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            check("rr_acc_gnt", 32'({gnt1, gnt0}), 32'h0);
            check("rr_acc_addr", mem_addr, (w == 0) ? addr0 : addr1);
            tick();
            prev = w;
        end
        #1;
        check("rr_last_done", 32'({done1, done0}), (prev == 0) ? 32'h1 : 32'h2);
        check("rr_last_rdata0", rdata0, model_rdata[0]);
        check("rr_last_rdata1", rdata1, model_rdata[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end
        legal_rs[0] = 3'b000; legal_rs[1] = 3'b001; legal_rs[2] = 3'b010;
        legal_rs[3] = 3'b101; legal_rs[4] = 3'b110;
        model_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        wsize0 = 2'b00; wsize1 = 2'b00; rsize0 = 3'b000; rsize1 = 3'b000;
        tick();
        tick();

        // Request while reset is held must not be granted
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        check("rst_gnt", 32'({gnt1, gnt0}), 32'h0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("reset_done", 32'({done1, done0}), 32'h0);
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_gnt", 32'({gnt1, gnt0}), 32'h0);
        check_idle_outputs("reset");
        tick();

        // Word write then word read
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 3'b000);
        do_access(0, 1'b0, 32'h10, 32'h0, 2'b00, 3'b000);
        check("lw_const", rdata0, 32'hDEADBEEF);

        // Byte store then signed and unsigned byte loads
        do_access(1, 1'b1, 32'h11, 32'h000000F0, 2'b01, 3'b000);
        do_access(1, 1'b0, 32'h11, 32'h0, 2'b00, 3'b001);
        check("lb_const", rdata1, 32'hFFFFFFF0);
        do_access(0, 1'b0, 32'h11, 32'h0, 2'b00, 3'b101);
        check("lbu_const", rdata0, 32'h000000F0);

        // Continuous contention
        rr_burst(8);

        // Illegal store size and illegal load size
        do_access(0, 1'b1, 32'h30, 32'h12345678, 2'b00, 3'b000);
        do_access(1, 1'b1, 32'h30, 32'hFFFFFFFF, 2'b11, 3'b000);
        check("err_set", 32'(err), 32'h1);
        do_access(1, 1'b0, 32'h30, 32'h0, 2'b00, 3'b000);
        check("bad_wsize_kept", rdata1, 32'h12345678);
        do_access(0, 1'b0, 32'h30, 32'h0, 2'b00, 3'b011);
        check("bad_rsize_zero", rdata0, 32'h0);
        check("err_sticky", 32'(err), 32'h1);

        // Randomized single-port traffic
        for (int i = 0; i < 24; i++) begin
            automatic int         p  = int'($urandom_range(0, 1));
            automatic logic       we = 1'($urandom_range(0, 1));
            automatic logic [1:0] ws = 2'($urandom_range(0, 3));
            automatic logic [2:0] rs;
            if ($urandom_range(0, 3) == 0) rs = 3'($urandom_range(0, 7));
            else rs = legal_rs[$urandom_range(0, 4)];
            do_access(p, we, 32'($urandom_range(0, 63)), $urandom, ws, rs);
        end
        rr_burst(4);

        // Reset during the ACCESS of a write to 0x20 holding zero
        do_access(1, 1'b1, 32'h20, 32'h0, 2'b00, 3'b000);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D; wsize0 = 2'b00;
        #1;
        check("abort_gnt", 32'({gnt1, gnt0}), 32'h1);
        tick();
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_rw_gated", 32'(mem_rw), 32'h0);
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_done", 32'({done1, done0}), 32'h0);
        check("abort_rdata0", rdata0, 32'h0);
        check("abort_rdata1", rdata1, 32'h0);
        check("abort_err", 32'(err), 32'h0);
        check("abort_gnt_idle", 32'({gnt1, gnt0}), 32'h0);
        check_idle_outputs("abort");
        tick();
        check("abort_no_late_done", 32'({done1, done0}), 32'h0);
        do_access(1, 1'b0, 32'h20, 32'h0, 2'b00, 3'b000);
        check("abort_no_write", rdata1, 32'h0);
        model_last = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        rr_burst(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
